// File: rtl/train_pkg.sv
// Shared types for the section occupancy detector.
// Holds the FSM state encoding and the occupancy counter width.
package train_pkg;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        OCCUPIED = 2'd1,
        FAULT    = 2'd2
    } state_t;
endpackage

// File: rtl/sensor_debounce.sv
// Purpose: debounce one raw sensor level and emit a one-cycle pulse on each accepted assertion.
// Latency: pulse is registered DEBOUNCE_CYCLES edges after the first raw-high edge.
// Backpressure: none; the pulse is always consumed on the following edge.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic evt
);
    localparam logic [3:0] THR = 4'(DEBOUNCE_CYCLES);

    logic [3:0] cnt_q, cnt_d;
    logic       evt_q, evt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!raw) begin
            cnt_d = '0;
        end else if (cnt_q != 4'hF) begin
            cnt_d = cnt_q + 4'd1;
        end
        // Debounced level is (cnt >= THR); pulse only on its 0->1 transition.
        evt_d = (cnt_d >= THR) && (cnt_q < THR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            evt_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            evt_q <= evt_d;
        end
    end

    assign evt = evt_q;
endmodule

// File: rtl/train_detect.sv
// Purpose: track trains in a section from entry/exit sensors; TRAIN_DETECT_HOLD_EN adds a post-clear hold on train.
// Latency: count/state change DEBOUNCE_CYCLES+1 edges after the first raw-high sensor edge.
// Backpressure: none; events arriving in FAULT are dropped until rst.
module train_detect
    import train_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_TRAINS      = 7,
    parameter int HOLD_CYCLES     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_in,
    input  logic             sensor_out,
    output logic             train,
    output logic [CNT_W-1:0] count,
    output logic             fault
);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_TRAINS);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range 1..15");
    end
    if (MAX_TRAINS < 1 || MAX_TRAINS > 15) begin : g_bad_max
        $error("MAX_TRAINS out of range 1..15");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("HOLD_CYCLES must be at least 1");
    end

    logic evt_in, evt_out;
    logic ent, ext;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_in (
        .clk (clk),
        .rst (rst),
        .raw (sensor_in),
        .evt (evt_in)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_out (
        .clk (clk),
        .rst (rst),
        .raw (sensor_out),
        .evt (evt_out)
    );

    // Coincident entry and exit cancel each other.
    assign ent = evt_in && !evt_out;
    assign ext = evt_out && !evt_in;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            FAULT: state_d = FAULT;
            default: begin
                if (ent) begin
                    if (count_q == MAX_C) begin
                        state_d = FAULT;
                    end else begin
                        count_d = count_q + 1'b1;
                        state_d = OCCUPIED;
                    end
                end else if (ext) begin
                    if (count_q == '0) begin
                        state_d = FAULT;
                    end else begin
                        count_d = count_q - 1'b1;
                        state_d = (count_q == CNT_W'(1)) ? EMPTY : OCCUPIED;
                    end
                end
            end
        endcase
    end

`ifdef TRAIN_DETECT_HOLD_EN
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;

    // Timer only runs while the section reads EMPTY; any other state clears it.
    always_comb begin
        hold_d = hold_q;
        if (state_q == OCCUPIED && state_d == EMPTY) begin
            hold_d = HOLD_W'(HOLD_CYCLES);
        end else if (state_d != EMPTY) begin
            hold_d = '0;
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    always_comb begin
        train = (state_q != EMPTY) || (hold_q != '0);
        fault = (state_q == FAULT);
    end
`else
    always_comb begin
        train = (state_q != EMPTY);
        fault = (state_q == FAULT);
    end
`endif

    assign count = count_q;
endmodule
